// File: rtl/ovrd_gain_ctrl.sv
// Overdrive gain controller: ramps the applied gain toward a requested target and
// backs the gain off when the datapath overflows too often within a monitor window.
module ovrd_gain_ctrl #(
    parameter int unsigned fxp_size           = 16,
    parameter int unsigned bits_per_gain_frac = 4,
    parameter int unsigned GAIN_STEP          = 1,
    parameter int unsigned GAIN_MAX           = 32'h0400,
    parameter int unsigned WIN_LOG2           = 8,
    parameter int unsigned OVF_THRESH         = 4,
    parameter int unsigned HOLD_WINDOWS       = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_sample_stb,
    input  logic [fxp_size-1:0] i_tgt_gain,
    input  logic                i_tgt_valid,
    output logic                o_tgt_ready,
    input  logic                i_overflow,
    output logic [fxp_size-1:0] o_gain,
    output logic                o_busy,
    output logic                o_limiting
);

    localparam int unsigned OvfW  = WIN_LOG2 + 1;
    localparam int unsigned HoldW = (HOLD_WINDOWS > 1) ? $clog2(HOLD_WINDOWS) : 1;

    localparam logic [fxp_size-1:0] Unity    = fxp_size'(1 << bits_per_gain_frac);
    localparam logic [fxp_size-1:0] GainMax  = fxp_size'(GAIN_MAX);
    localparam logic [fxp_size-1:0] Step     = fxp_size'(GAIN_STEP);
    localparam logic [WIN_LOG2-1:0] WinLast  = '1;
    localparam logic [OvfW-1:0]     OvfSat   = OvfW'(1 << WIN_LOG2);
    localparam logic [OvfW-1:0]     OvfThr   = OvfW'(OVF_THRESH);
    localparam logic [HoldW-1:0]    HoldLast = HoldW'(HOLD_WINDOWS - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRamp  = 2'd1,
        StLimit = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [fxp_size-1:0] gain_q, gain_d;
    logic [fxp_size-1:0] tgt_q, tgt_d;
    logic [WIN_LOG2-1:0] win_q, win_d;
    logic [OvfW-1:0]     ovf_q, ovf_d;
    logic [HoldW-1:0]    hold_q, hold_d;

    logic                win_close;
    logic [OvfW-1:0]     ovf_total;
    logic                limit_trig;
    logic                tgt_ready;
    logic                accept;
    logic [fxp_size-1:0] tgt_sat;
    logic [fxp_size-1:0] tgt_eff;
    logic [fxp_size-1:0] gain_cut;
    logic [fxp_size-1:0] gain_lim;
    logic [fxp_size-1:0] diff;

    always_comb begin
        win_close = i_sample_stb && (win_q == WinLast);
        // The closing strobe's own overflow belongs to the window it closes.
        ovf_total = (i_sample_stb && i_overflow && (ovf_q != OvfSat)) ? ovf_q + 1'b1 : ovf_q;
        tgt_ready = (state_q != StLimit);
        limit_trig = win_close && tgt_ready && (ovf_total >= OvfThr);
        accept    = i_tgt_valid && tgt_ready && !limit_trig;
        tgt_sat   = (i_tgt_gain > GainMax) ? GainMax : i_tgt_gain;
        tgt_eff   = accept ? tgt_sat : tgt_q;
        gain_cut  = gain_q - (gain_q >> 3);
        gain_lim  = (gain_cut < Unity) ? Unity : gain_cut;
        diff      = (tgt_eff >= gain_q) ? tgt_eff - gain_q : gain_q - tgt_eff;
    end

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        tgt_d   = accept ? tgt_sat : tgt_q;
        hold_d  = hold_q;
        win_d   = i_sample_stb ? win_q + 1'b1 : win_q;
        ovf_d   = win_close ? '0 : ovf_total;

        unique case (state_q)
            StIdle: begin
                if (limit_trig) begin
                    state_d = StLimit;
                    gain_d  = gain_lim;
                    hold_d  = '0;
                end else if (accept && (tgt_sat != gain_q)) begin
                    state_d = StRamp;
                end
            end
            StRamp: begin
                if (limit_trig) begin
                    state_d = StLimit;
                    gain_d  = gain_lim;
                    hold_d  = '0;
                end else if (i_sample_stb) begin
                    if (diff <= Step) begin
                        gain_d  = tgt_eff;
                        state_d = StIdle;
                    end else if (tgt_eff > gain_q) begin
                        gain_d = gain_q + Step;
                    end else begin
                        gain_d = gain_q - Step;
                    end
                end
            end
            StLimit: begin
                if (win_close) begin
                    if (hold_q == HoldLast) begin
                        hold_d  = '0;
                        state_d = (gain_q != tgt_q) ? StRamp : StIdle;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            gain_q  <= Unity;
            tgt_q   <= Unity;
            win_q   <= '0;
            ovf_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            tgt_q   <= tgt_d;
            win_q   <= win_d;
            ovf_q   <= ovf_d;
            hold_q  <= hold_d;
        end
    end

    assign o_gain      = gain_q;
    assign o_tgt_ready = tgt_ready;
    assign o_busy      = (state_q == StRamp);
    assign o_limiting  = (state_q == StLimit);

endmodule
